// File: rtl/vga_bcd_field.sv
// vga_bcd_field: renders NUM_GROUPS two-digit BCD groups as scaled 8x16 glyphs on the VGA raster
//  Optional feature macro: VGA_BCD_BLINK_EN (blink the group selected for editing).
//  Ports:
//   clk, reset         pixel clock, synchronous active-high reset
//   video_on, pix_x/y  raster position and active-video flag
//   enable             field enable; low forces the field off
//   edit_req/edit_addr edit mode request and address of the edited field
//   digits_in          packed BCD groups, group 0 in the LSB byte, tens in [7:4]
//   font_addr/data     synchronous font ROM interface {char,row} -> row bits (bit 7 leftmost)
//   rgb_out, in_field  registered colour and hit flag, 3 clk after the pixel inputs
module vga_bcd_field #(
   parameter int NUM_GROUPS = 3,
   parameter int X0 = 192,
   parameter int Y0 = 320,
   parameter int GROUP_PITCH = 128,
   parameter int SCALE_LOG2 = 2,
   parameter logic [11:0] FG_RGB = 12'h0FF,
   parameter logic [11:0] HL_RGB = 12'hF00,
   parameter int HL_BASE = 6,
   parameter int BLINK_LOG2 = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic video_on,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic enable,
   input  logic edit_req,
   input  logic [3:0] edit_addr,
   input  logic [8*NUM_GROUPS-1:0] digits_in,
   output logic [7:0] font_addr,
   input  logic [7:0] font_data,
   output logic [11:0] rgb_out,
   output logic in_field
);
   localparam int W = 8 << SCALE_LOG2;
   localparam int H = 16 << SCALE_LOG2;
   localparam int GW = NUM_GROUPS > 1 ? $clog2(NUM_GROUPS) : 1;
   typedef enum logic {NORMAL, EDIT} mode_t;
   mode_t mode;
   logic [8*NUM_GROUPS-1:0] snapshot;
   logic frame_start, hit, hit1, hit2, vid1, vid2, blank1, blank2, sel, off, on;
   logic [GW-1:0] grp, grp1, grp2;
   logic [3:0] nib;
   logic [2:0] col1, col2;
   int dx, dy;
   // Find the digit cell under the pixel; dx is the offset from that cell's left edge.
   always_comb begin
      dy = int'(pix_y) - Y0;
      dx = 0;
      hit = 1'b0;
      grp = '0;
      nib = '0;
      for (int g = 0; g < NUM_GROUPS; g++)
         for (int u = 0; u < 2; u++)
            if (int'(pix_x) >= X0 + g*GROUP_PITCH + u*W && int'(pix_x) < X0 + g*GROUP_PITCH + (u+1)*W) begin
               hit = dy >= 0 && dy < H;
               grp = GW'(g);
               nib = snapshot[8*g + 4*(1-u) +: 4];
               dx = int'(pix_x) - X0 - g*GROUP_PITCH - u*W;
            end
   end
   assign frame_start = pix_x == 10'd0 && pix_y == 10'd0;
   assign sel = mode == EDIT && int'(edit_addr) == HL_BASE + int'(grp2);
`ifdef VGA_BCD_BLINK_EN
   localparam int CW = BLINK_LOG2 + 1;
   logic [CW-1:0] cnt;
   assign off = sel && cnt[CW-1];
`else
   // BLINK_LOG2 only matters with blinking; the highlight stays steady here.
   assign off = BLINK_LOG2 < 0;
`endif
   // font_data is the ROM's own register, already aligned with the S2 stage registers.
   assign on = hit2 && vid2 && enable && !blank2 && font_data[3'd7 - col2] && !off;
   always_ff @(posedge clk)
      if (reset) begin
         mode <= NORMAL;
         snapshot <= '0;
`ifdef VGA_BCD_BLINK_EN
         cnt <= '0;
`endif
         font_addr <= '0;
         col1 <= '0;
         grp1 <= '0;
         hit1 <= 1'b0;
         vid1 <= 1'b0;
         blank1 <= 1'b0;
         col2 <= '0;
         grp2 <= '0;
         hit2 <= 1'b0;
         vid2 <= 1'b0;
         blank2 <= 1'b0;
         rgb_out <= '0;
         in_field <= 1'b0;
      end else begin
         if (frame_start) begin
            snapshot <= digits_in;
            mode <= edit_req ? EDIT : NORMAL;
`ifdef VGA_BCD_BLINK_EN
            cnt <= (mode == NORMAL && edit_req) ? '0 : cnt + CW'(1);
`endif
         end
         font_addr <= {nib, 4'(dy >> SCALE_LOG2)};
         col1 <= 3'(dx >> SCALE_LOG2);
         grp1 <= grp;
         hit1 <= hit;
         vid1 <= video_on;
         blank1 <= nib > 4'd9;
         col2 <= col1;
         grp2 <= grp1;
         hit2 <= hit1;
         vid2 <= vid1;
         blank2 <= blank1;
         rgb_out <= on ? (sel ? HL_RGB : FG_RGB) : 12'h000;
         in_field <= hit2 && enable;
      end
endmodule
